// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module   : alu_reservation_station
// Brief    : ALU/branch reservation station with CDB operand capture and
//            oldest-ready issue. Optional macro RS_CDB_BYPASS_EN lets an entry
//            issue in the same cycle its last operand is broadcast.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package alu_rs_pkg;
    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       is_branch;
    } control_t;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH     = 4,
    parameter int RS_IDX_WIDTH = $clog2(RS_DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                alloc_valid,
    output logic                                alloc_ready,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]  alloc_src1_tag,
    input  logic                                alloc_src1_rdy,
    input  logic [`REG_VAL_WIDTH-1:0]           alloc_src1_val,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]  alloc_src2_tag,
    input  logic                                alloc_src2_rdy,
    input  logic [`REG_VAL_WIDTH-1:0]           alloc_src2_val,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]  alloc_dst_reg_addr,
    input  control_t                            alloc_control,
    input  logic [`REG_VAL_WIDTH-1:0]           alloc_immediate,
    input  logic [`INST_ADDR_WIDTH-1:0]         alloc_pc,
    input  logic [`ROB_SIZE_WIDTH-1:0]          alloc_rob_tag,
    input  logic                                cdb_valid,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]  cdb_addr,
    input  logic [`REG_VAL_WIDTH-1:0]           cdb_val,
    input  logic                                alu_ready,
    output logic                                rs_valid,
    output logic [`REG_VAL_WIDTH-1:0]           src_reg1_val,
    output logic [`REG_VAL_WIDTH-1:0]           src_reg2_val,
    output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]  dst_reg_addr,
    output control_t                            control,
    output logic [`REG_VAL_WIDTH-1:0]           immediate,
    output logic [`INST_ADDR_WIDTH-1:0]         pc_in,
    output logic [`ROB_SIZE_WIDTH-1:0]          new_inst_tag_in
);

    localparam int VW    = `REG_VAL_WIDTH;
    localparam int TW    = `PHYSICAL_REG_NUM_WIDTH;
    localparam int AW    = `INST_ADDR_WIDTH;
    localparam int RW    = `ROB_SIZE_WIDTH;
    localparam int CNT_W = RS_IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RS_DEPTH);

    // Entry storage
    logic [RS_DEPTH-1:0]     valid_q, valid_d;
    logic [RS_DEPTH-1:0]     s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [VW-1:0]           s1_val_q [RS_DEPTH];
    logic [VW-1:0]           s1_val_d [RS_DEPTH];
    logic [VW-1:0]           s2_val_q [RS_DEPTH];
    logic [VW-1:0]           s2_val_d [RS_DEPTH];
    logic [TW-1:0]           s1_tag_q [RS_DEPTH];
    logic [TW-1:0]           s1_tag_d [RS_DEPTH];
    logic [TW-1:0]           s2_tag_q [RS_DEPTH];
    logic [TW-1:0]           s2_tag_d [RS_DEPTH];
    logic [TW-1:0]           dst_q    [RS_DEPTH];
    logic [TW-1:0]           dst_d    [RS_DEPTH];
    control_t                ctrl_q   [RS_DEPTH];
    control_t                ctrl_d   [RS_DEPTH];
    logic [VW-1:0]           imm_q    [RS_DEPTH];
    logic [VW-1:0]           imm_d    [RS_DEPTH];
    logic [AW-1:0]           pc_q     [RS_DEPTH];
    logic [AW-1:0]           pc_d     [RS_DEPTH];
    logic [RW-1:0]           rob_q    [RS_DEPTH];
    logic [RW-1:0]           rob_d    [RS_DEPTH];
    logic [RS_IDX_WIDTH-1:0] age_q    [RS_DEPTH];
    logic [RS_IDX_WIDTH-1:0] age_d    [RS_DEPTH];

    // Issue-port registers
    logic          rs_valid_q, rs_valid_d;
    logic [VW-1:0] out_s1_q, out_s1_d, out_s2_q, out_s2_d, out_imm_q, out_imm_d;
    logic [TW-1:0] out_dst_q, out_dst_d;
    control_t      out_ctrl_q, out_ctrl_d;
    logic [AW-1:0] out_pc_q, out_pc_d;
    logic [RW-1:0] out_rob_q, out_rob_d;

    logic [CNT_W-1:0]        valid_cnt;
    logic [RS_DEPTH-1:0]     s1_hit, s2_hit, eligible;
    logic [RS_IDX_WIDTH-1:0] alloc_idx, sel_idx, sel_age, new_age;
    logic                    do_issue, alloc_fire, a1_hit, a2_hit;

    always_comb begin
        valid_cnt = '0;
        s1_hit    = '0;
        s2_hit    = '0;
        eligible  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_cnt = valid_cnt + CNT_W'(valid_q[i]);
            s1_hit[i] = cdb_valid && !s1_rdy_q[i] && (s1_tag_q[i] == cdb_addr);
            s2_hit[i] = cdb_valid && !s2_rdy_q[i] && (s2_tag_q[i] == cdb_addr);
`ifdef RS_CDB_BYPASS_EN
            eligible[i] = valid_q[i] && (s1_rdy_q[i] || s1_hit[i])
                                     && (s2_rdy_q[i] || s2_hit[i]);
`else
            eligible[i] = valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i];
`endif
        end
    end

    // Lowest free slot for allocation; lowest age rank among eligible for issue
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = RS_IDX_WIDTH'(i);
        end
        sel_idx = '0;
        sel_age = '1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (eligible[i] && (age_q[i] <= sel_age)) begin
                sel_idx = RS_IDX_WIDTH'(i);
                sel_age = age_q[i];
            end
        end
    end

    assign alloc_ready = (valid_cnt < C_DEPTH);
    assign do_issue    = alu_ready && !rs_valid_q && (|eligible) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    // Survivors keep ranks 0..n-1, so the newcomer takes the count after issue
    assign new_age     = RS_IDX_WIDTH'(valid_cnt - CNT_W'(do_issue));
    assign a1_hit      = cdb_valid && !alloc_src1_rdy && (cdb_addr == alloc_src1_tag);
    assign a2_hit      = cdb_valid && !alloc_src2_rdy && (cdb_addr == alloc_src2_tag);

    always_comb begin
        valid_d    = valid_q;
        s1_rdy_d   = s1_rdy_q;
        s2_rdy_d   = s2_rdy_q;
        s1_val_d   = s1_val_q;
        s2_val_d   = s2_val_q;
        s1_tag_d   = s1_tag_q;
        s2_tag_d   = s2_tag_q;
        dst_d      = dst_q;
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rob_d      = rob_q;
        age_d      = age_q;
        rs_valid_d = do_issue;
        out_s1_d   = out_s1_q;
        out_s2_d   = out_s2_q;
        out_dst_d  = out_dst_q;
        out_ctrl_d = out_ctrl_q;
        out_imm_d  = out_imm_q;
        out_pc_d   = out_pc_q;
        out_rob_d  = out_rob_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i]) begin
                if (s1_hit[i]) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = cdb_val;
                end
                if (s2_hit[i]) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = cdb_val;
                end
                if (do_issue && (age_q[i] > sel_age)) begin
                    age_d[i] = age_q[i] - RS_IDX_WIDTH'(1);
                end
            end
        end

        if (do_issue) begin
            valid_d[sel_idx] = 1'b0;
`ifdef RS_CDB_BYPASS_EN
            out_s1_d = s1_rdy_q[sel_idx] ? s1_val_q[sel_idx] : cdb_val;
            out_s2_d = s2_rdy_q[sel_idx] ? s2_val_q[sel_idx] : cdb_val;
`else
            out_s1_d = s1_val_q[sel_idx];
            out_s2_d = s2_val_q[sel_idx];
`endif
            out_dst_d  = dst_q[sel_idx];
            out_ctrl_d = ctrl_q[sel_idx];
            out_imm_d  = imm_q[sel_idx];
            out_pc_d   = pc_q[sel_idx];
            out_rob_d  = rob_q[sel_idx];
        end

        if (alloc_fire) begin
            valid_d[alloc_idx]  = 1'b1;
            s1_rdy_d[alloc_idx] = alloc_src1_rdy || a1_hit;
            s2_rdy_d[alloc_idx] = alloc_src2_rdy || a2_hit;
            s1_val_d[alloc_idx] = a1_hit ? cdb_val : alloc_src1_val;
            s2_val_d[alloc_idx] = a2_hit ? cdb_val : alloc_src2_val;
            s1_tag_d[alloc_idx] = alloc_src1_tag;
            s2_tag_d[alloc_idx] = alloc_src2_tag;
            dst_d[alloc_idx]    = alloc_dst_reg_addr;
            ctrl_d[alloc_idx]   = alloc_control;
            imm_d[alloc_idx]    = alloc_immediate;
            pc_d[alloc_idx]     = alloc_pc;
            rob_d[alloc_idx]    = alloc_rob_tag;
            age_d[alloc_idx]    = new_age;
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            s1_rdy_q   <= '0;
            s2_rdy_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                dst_q[i]    <= '0;
                ctrl_q[i]   <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
                rob_q[i]    <= '0;
                age_q[i]    <= '0;
            end
            rs_valid_q <= 1'b0;
            out_s1_q   <= '0;
            out_s2_q   <= '0;
            out_dst_q  <= '0;
            out_ctrl_q <= '0;
            out_imm_q  <= '0;
            out_pc_q   <= '0;
            out_rob_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            s1_rdy_q   <= s1_rdy_d;
            s2_rdy_q   <= s2_rdy_d;
            s1_val_q   <= s1_val_d;
            s2_val_q   <= s2_val_d;
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
            dst_q      <= dst_d;
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rob_q      <= rob_d;
            age_q      <= age_d;
            rs_valid_q <= rs_valid_d;
            out_s1_q   <= out_s1_d;
            out_s2_q   <= out_s2_d;
            out_dst_q  <= out_dst_d;
            out_ctrl_q <= out_ctrl_d;
            out_imm_q  <= out_imm_d;
            out_pc_q   <= out_pc_d;
            out_rob_q  <= out_rob_d;
        end
    end

    assign rs_valid        = rs_valid_q;
    assign src_reg1_val    = out_s1_q;
    assign src_reg2_val    = out_s2_q;
    assign dst_reg_addr    = out_dst_q;
    assign control         = out_ctrl_q;
    assign immediate       = out_imm_q;
    assign pc_in           = out_pc_q;
    assign new_inst_tag_in = out_rob_q;

endmodule

`default_nettype wire

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station directly upstream of the ALU. Holds up to RS_DEPTH renamed ALU/branch instructions from dispatch and captures missing source operands from the CDB by physical-register tag. Each cycle it issues the oldest fully-ready entry to the ALU through the rs_valid / alu_ready handshake. The issue-port signals map one-to-one onto the ALU input ports.

Parameters:
RS_DEPTH, 4, number of entries (power of two, >=2)
RS_IDX_WIDTH, $clog2(RS_DEPTH), entry index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  misprediction flush; discards all entries
alloc_valid  in  1  dispatch presents an instruction
alloc_ready  out  1  at least one free entry
alloc_src1_tag  in  `PHYSICAL_REG_NUM_WIDTH  src1 physical tag
alloc_src1_rdy  in  1  src1 value valid at dispatch
alloc_src1_val  in  `REG_VAL_WIDTH  src1 value
alloc_src2_tag  in  `PHYSICAL_REG_NUM_WIDTH  src2 physical tag
alloc_src2_rdy  in  1  src2 value valid at dispatch
alloc_src2_val  in  `REG_VAL_WIDTH  src2 value
alloc_dst_reg_addr  in  `PHYSICAL_REG_NUM_WIDTH  destination physical register
alloc_control  in  control_t  decoded control
alloc_immediate  in  `REG_VAL_WIDTH  immediate
alloc_pc  in  `INST_ADDR_WIDTH  instruction PC
alloc_rob_tag  in  `ROB_SIZE_WIDTH  ROB tag
cdb_valid  in  1  CDB broadcast valid
cdb_addr  in  `PHYSICAL_REG_NUM_WIDTH  broadcast physical tag
cdb_val  in  `REG_VAL_WIDTH  broadcast value
alu_ready  in  1  ALU idle
rs_valid  out  1  issue strobe, one cycle per instruction
src_reg1_val, src_reg2_val  out  `REG_VAL_WIDTH  issued operands
dst_reg_addr  out  `PHYSICAL_REG_NUM_WIDTH  issued destination
control  out  control_t  issued control
immediate  out  `REG_VAL_WIDTH  issued immediate
pc_in  out  `INST_ADDR_WIDTH  issued PC
new_inst_tag_in  out  `ROB_SIZE_WIDTH  issued ROB tag

Behaviour:
- Reset (synchronous, active-high): all entries invalid; rs_valid=0; all issue data outputs=0; alloc_ready=1.
- Entry state: valid, src1_rdy, src2_rdy, two values, two tags, payload, and an allocation-age rank.
- alloc_ready = (valid count < RS_DEPTH). Computed from registered state only. A slot freed by issue in cycle t is allocatable from t+1.
- Allocation:
  - alloc_valid && alloc_ready writes the lowest-index free entry at the clock edge.
  - If cdb_valid && cdb_addr == alloc_srcN_tag && !alloc_srcN_rdy in the same cycle, the entry stores cdb_val with rdy=1 (dispatch/CDB race).
- Wakeup: each valid entry with srcN_rdy=0 and tag == cdb_addr under cdb_valid captures cdb_val and sets rdy=1. Both sources may wake on the same broadcast.
- Issue condition: alu_ready && !rs_valid && at least one entry with valid, src1_rdy and src2_rdy all set.
  - Select the oldest such entry by allocation order. Ages are strict, so no ties.
  - Issue data and rs_valid=1 are registered; they appear the cycle after selection and the entry is freed at the same edge.
  - rs_valid deasserts the following cycle unless a new issue is selected. Back-to-back issue is impossible because of !rs_valid; minimum issue spacing is 2 cycles.
  - Data outputs hold their last values while rs_valid=0.
- Readiness latency, without bypass: an operand woken by the CDB in cycle t makes its entry issue-eligible in t+1 (rs_valid at t+2).
- Simultaneous events: allocate + issue + wakeup in one cycle are independent and all take effect. A wakeup on the entry being issued is ignored.
- Flush (priority below reset, above everything else): all entries invalid, rs_valid=0 next cycle, allocation that cycle dropped.
- Reset or flush mid-operation discards all state. Nothing already presented to the ALU is retracted.

Optional Feature:
RS_CDB_BYPASS_EN
- Defined: an entry whose last missing operand matches the current CDB broadcast is issue-eligible in that same cycle. cdb_val is forwarded into the issued operand, so rs_valid appears at t+1.
- Undefined: one extra cycle of wakeup latency, as described above.

Test Plan:
- Reset, then alloc one entry with src1=5, src2=7, both rdy, alu_ready=1 -> rs_valid=1 one cycle later with src_reg1_val=5, src_reg2_val=7; alloc_ready stays 1.
- Alloc src1 tag 12 not ready, src2 ready=3; cdb_valid, addr=12, val=40 two cycles later -> rs_valid at CDB+2 (CDB+1 with RS_CDB_BYPASS_EN) carrying 40 and 3.
- Fill 4 entries, all ready, alu_ready held 0 -> alloc_ready=0, 5th alloc ignored; release alu_ready -> issue in allocation order A,B,C,D, one every 2 cycles.
- Alloc with tag 9 not ready while cdb_valid, addr=9, val=0xFF same cycle -> entry stored ready, issues with 0xFF.
- Two entries ready, younger woken first -> older still issues first when both ready.
- Full RS, assert flush with alloc_valid=1 -> next cycle all empty, alloc_ready=1, rs_valid=0, no later issue of flushed entries.
